// File: rtl/mems_pkg.sv
// Shared definitions for the MEMS microphone capture controller.
//   state_e      : capture FSM states
//   ERR_*        : err_code_o encodings
//   DW_DEFAULT   : default PCM sample width
package mems_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam int unsigned DW_DEFAULT = 16;

endpackage

// File: rtl/mems_capture_ctrl_if.sv
// Frame output bus from the capture controller to the downstream CNN buffer.
//   frm_data_o  : frame sample
//   frm_idx_o   : sample index within the frame
//   frm_last_o  : marks the final sample of the frame
//   frm_valid_o : sample available
//   frm_ready_i : consumer accepts the sample this cycle
// master = capture controller, slave = consumer.
interface mems_capture_ctrl_if
    import mems_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned IW = 8
);
    logic [DW-1:0] frm_data_o;
    logic [IW-1:0] frm_idx_o;
    logic          frm_last_o;
    logic          frm_valid_o;
    logic          frm_ready_i;

    modport master (
        output frm_data_o,
        output frm_idx_o,
        output frm_last_o,
        output frm_valid_o,
        input  frm_ready_i
    );

    modport slave (
        input  frm_data_o,
        input  frm_idx_o,
        input  frm_last_o,
        input  frm_valid_o,
        output frm_ready_i
    );
endinterface

// File: rtl/mems_frm_fifo.sv
// Two-entry FIFO for frame payloads. The head entry is always held in
// head_q so the output is straight from a register and stays stable until
// popped.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   push_i, push_data_i : write an entry (caller never pushes when full
//                         without a same-cycle pop)
//   pop_i            : remove head entry (ignored when empty)
//   flush_i          : discard all entries
//   head_o           : current head entry
//   empty_o, full_o  : occupancy flags
module mems_frm_fifo #(
    parameter int unsigned PW = 25
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          push_i,
    input  logic [PW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [PW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [1:0]    cnt_q;
    logic          pop_ok;

    assign pop_ok  = pop_i & (cnt_q != 2'd0);
    assign head_o  = head_q;
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);

    // Occupancy and storage update; push+pop on a full FIFO shifts tail to head.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_i, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= push_data_i;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= push_data_i;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= push_data_i;
                    end else begin
                        head_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mems_capture_ctrl.sv
// MEMS microphone frame capture controller. Enables the mic, drops the
// decimator start-up samples, captures FRAME_LEN samples into a 2-entry
// output FIFO and reports overflow, strobe timeout or abort as a sticky error.
//   sys_clk, sys_rst   : clock, synchronous active-high reset
//   start_i, abort_i   : one-cycle capture request / abort request
//   chan_sel_i         : requested channel (0 = L, 1 = R)
//   smp_data_i/valid_i : decimated sample and its strobe
//   mic_en_o, sel_lr_o : microphone enable and L/R select
//   frm                : frame output bus (data, idx, last, valid/ready)
//   busy_o, done_o     : not idle / frame complete pulse
//   err_o, err_code_o  : sticky error and its cause
module mems_capture_ctrl
    import mems_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned DISCARD   = 16,
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 chan_sel_i,
    input  logic [DW-1:0]        smp_data_i,
    input  logic                 smp_valid_i,
    output logic                 mic_en_o,
    output logic                 sel_lr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    mems_capture_ctrl_if.master  frm
);
    localparam int unsigned IW  = $clog2(FRAME_LEN);
    localparam int unsigned PW  = DW + IW + 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned DCW = $clog2(DISCARD + 2);

    state_e          state_q;
    logic            mic_en_q;
    logic            sel_lr_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [1:0]      err_code_q;
    logic [DCW-1:0]  dcnt_q;
    logic [IW-1:0]   scnt_q;
    logic [TW-1:0]   tmo_q;

    logic [PW-1:0]   fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop_c;
    logic            push_c;
    logic            run_c;
    logic            abort_c;
    logic            ovf_c;
    logic            tmo_c;
    logic            flush_c;
    logic [PW-1:0]   push_data_c;

    // Error/handshake qualifiers; abort outranks overflow and timeout.
    assign run_c   = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign pop_c   = ~fifo_empty & frm.frm_ready_i;
    assign abort_c = abort_i & (run_c || (state_q == ST_DRAIN));
    assign ovf_c   = (state_q == ST_CAPTURE) & smp_valid_i & fifo_full & ~pop_c;
    assign tmo_c   = run_c & ~smp_valid_i & (tmo_q == TW'(TIMEOUT - 1));
    assign push_c  = (state_q == ST_CAPTURE) & smp_valid_i & ~abort_c & ~ovf_c;
    assign flush_c = abort_c | ovf_c | tmo_c;

    assign push_data_c = {(scnt_q == IW'(FRAME_LEN - 1)), scnt_q, smp_data_i};

    mems_frm_fifo #(.PW(PW)) u_fifo (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .push_i      (push_c),
        .push_data_i (push_data_c),
        .pop_i       (pop_c),
        .flush_i     (flush_c),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Capture sequencing FSM with registered status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            mic_en_q   <= 1'b0;
            sel_lr_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            dcnt_q     <= '0;
            scnt_q     <= '0;
            tmo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_c) begin
                state_q    <= ST_ERR;
                mic_en_q   <= 1'b0;
                busy_q     <= 1'b1;
                err_q      <= 1'b1;
                err_code_q <= abort_c ? ERR_ABORT : (ovf_c ? ERR_OVF : ERR_TMO);
            end else begin
                case (state_q)
                    ST_IDLE, ST_ERR: begin
                        if (start_i) begin
                            state_q    <= (DISCARD == 0) ? ST_CAPTURE : ST_SETTLE;
                            sel_lr_q   <= chan_sel_i;
                            mic_en_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            err_q      <= 1'b0;
                            err_code_q <= ERR_NONE;
                            dcnt_q     <= '0;
                            scnt_q     <= '0;
                            tmo_q      <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (smp_valid_i) begin
                            tmo_q <= '0;
                            if (dcnt_q == DCW'(DISCARD - 1)) begin
                                state_q <= ST_CAPTURE;
                            end else begin
                                dcnt_q <= dcnt_q + DCW'(1);
                            end
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        if (smp_valid_i) begin
                            tmo_q  <= '0;
                            scnt_q <= scnt_q + IW'(1);
                            if (scnt_q == IW'(FRAME_LEN - 1)) begin
                                state_q  <= ST_DRAIN;
                                mic_en_q <= 1'b0;
                            end
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        // Popping while exactly one entry remains empties the frame.
                        if (pop_c && !fifo_full) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mic_en_o   = mic_en_q;
    assign sel_lr_o   = sel_lr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

    assign frm.frm_data_o  = fifo_head[DW-1:0];
    assign frm.frm_idx_o   = fifo_head[DW +: IW];
    assign frm.frm_last_o  = fifo_head[PW-1];
    assign frm.frm_valid_o = ~fifo_empty;
endmodule

// File: tb/tb_mems_capture_ctrl.sv
// Directed bench for mems_capture_ctrl with a scoreboard of expected frame
// samples checked on every output handshake.
module tb_mems_capture_ctrl;
    import mems_pkg::*;

    localparam int unsigned FL   = 256;
    localparam int unsigned DISC = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned TMO  = 4096;
    localparam int unsigned IW   = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start_i;
    logic          abort_i;
    logic          chan_sel_i;
    logic [DW-1:0] smp_data_i;
    logic          smp_valid_i;
    logic          mic_en_o;
    logic          sel_lr_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    mems_capture_ctrl_if #(.DW(DW), .IW(IW)) frm ();

    mems_capture_ctrl #(
        .FRAME_LEN (FL),
        .DISCARD   (DISC),
        .DW        (DW),
        .TIMEOUT   (TMO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .chan_sel_i  (chan_sel_i),
        .smp_data_i  (smp_data_i),
        .smp_valid_i (smp_valid_i),
        .mic_en_o    (mic_en_o),
        .sel_lr_o    (sel_lr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .frm         (frm)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          last;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_pop  = 0;
    int   n_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted output sample must match the oldest expected one.
    always @(negedge sys_clk) begin
        if (frm.frm_valid_o === 1'b1 && frm.frm_ready_i === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL pop_unexpected observed_idx=%0d expected=none", frm.frm_idx_o);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("pop_data", 32'(frm.frm_data_o), 32'(mon_e.data));
                chk("pop_idx",  32'(frm.frm_idx_o),  32'(mon_e.idx));
                chk("pop_last", 32'(frm.frm_last_o), 32'(mon_e.last));
                n_pop++;
            end
        end
        if (done_o === 1'b1) n_done++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_cap(input logic ch);
        start_i    = 1'b1;
        chan_sel_i = ch;
        step();
        start_i    = 1'b0;
    endtask

    // Drive strobes number first..first+count-1 since start; captured ones go to the scoreboard.
    task automatic strobe_seq(input int first, input int count, input int gap);
        logic [DW-1:0] d;
        int            k;
        for (int i = 0; i < count; i++) begin
            k = first + i;
            d = DW'($urandom);
            if (k >= int'(DISC)) begin
                sb.push_back({(k - int'(DISC)) == int'(FL - 1), IW'(k - int'(DISC)), d});
            end
            smp_valid_i = 1'b1;
            smp_data_i  = d;
            step();
            smp_valid_i = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    task automatic wait_done(input string tag, input int base);
        for (int i = 0; i < 50 && n_done == base; i++) step();
        repeat (5) step();
        chk({tag, "_done_cnt"}, 32'(n_done - base), 32'd1);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_mic_en"},   32'(mic_en_o),        32'd0);
        chk({p, "_sel_lr"},   32'(sel_lr_o),        32'd0);
        chk({p, "_valid"},    32'(frm.frm_valid_o), 32'd0);
        chk({p, "_data"},     32'(frm.frm_data_o),  32'd0);
        chk({p, "_idx"},      32'(frm.frm_idx_o),   32'd0);
        chk({p, "_last"},     32'(frm.frm_last_o),  32'd0);
        chk({p, "_busy"},     32'(busy_o),          32'd0);
        chk({p, "_done"},     32'(done_o),          32'd0);
        chk({p, "_err"},      32'(err_o),           32'd0);
        chk({p, "_err_code"}, 32'(err_code_o),      32'd0);
    endtask

    initial begin
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        int            base_done;
        int            base_pop;
        int            n;

        sys_rst         = 1'b1;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        chan_sel_i      = 1'b0;
        smp_data_i      = '0;
        smp_valid_i     = 1'b0;
        frm.frm_ready_i = 1'b0;
        repeat (3) step();
        sys_rst = 1'b0;
        chk_reset("rst");

        // Full frame, right channel, slow strobes, always ready.
        frm.frm_ready_i = 1'b1;
        base_done = n_done;
        base_pop  = n_pop;
        start_cap(1'b1);
        chk("t1_sel_lr", 32'(sel_lr_o), 32'd1);
        chk("t1_mic_en", 32'(mic_en_o), 32'd1);
        chk("t1_busy",   32'(busy_o),   32'd1);
        strobe_seq(0, int'(DISC + FL), 64);
        wait_done("t1", base_done);
        chk("t1_pops",     32'(n_pop - base_pop), 32'(FL));
        chk("t1_sb_empty", 32'(sb.size()),        32'd0);
        chk("t1_busy_end", 32'(busy_o),           32'd0);
        chk("t1_mic_off",  32'(mic_en_o),         32'd0);

        // Overflow: consumer stalled for three captured strobes.
        frm.frm_ready_i = 1'b0;
        start_cap(1'b0);
        chk("t2_sel_lr", 32'(sel_lr_o), 32'd0);
        strobe_seq(0, int'(DISC), 4);
        da = DW'($urandom);
        db = DW'($urandom);
        smp_valid_i = 1'b1; smp_data_i = da; step(); smp_valid_i = 1'b0; step();
        chk("t2_valid_1", 32'(frm.frm_valid_o), 32'd1);
        chk("t2_data_1",  32'(frm.frm_data_o),  32'(da));
        chk("t2_idx_1",   32'(frm.frm_idx_o),   32'd0);
        smp_valid_i = 1'b1; smp_data_i = db; step(); smp_valid_i = 1'b0; step();
        chk("t2_data_hold", 32'(frm.frm_data_o), 32'(da));
        chk("t2_err_pre",   32'(err_o),          32'd0);
        smp_valid_i = 1'b1; smp_data_i = DW'($urandom); step(); smp_valid_i = 1'b0;
        chk("t2_err_code", 32'(err_code_o),      32'(ERR_OVF));
        chk("t2_err",      32'(err_o),           32'd1);
        chk("t2_mic_en",   32'(mic_en_o),        32'd0);
        chk("t2_valid",    32'(frm.frm_valid_o), 32'd0);
        chk("t2_busy",     32'(busy_o),          32'd1);

        // Timeout: strobes stop mid-capture.
        frm.frm_ready_i = 1'b1;
        start_cap(1'b1);
        chk("t3_err_clr",  32'(err_o),      32'd0);
        chk("t3_code_clr", 32'(err_code_o), 32'd0);
        strobe_seq(0, int'(DISC) + 5, 3);
        n = 0;
        while (err_o !== 1'b1 && n < int'(TMO) + 100) begin
            step();
            n++;
        end
        chk("t3_tmo_cycles", 32'(n),          32'(TMO - 2));
        chk("t3_err_code",   32'(err_code_o), 32'(ERR_TMO));
        chk("t3_err",        32'(err_o),      32'd1);
        chk("t3_mic_en",     32'(mic_en_o),   32'd0);

        // Restart from ERR; strobe every 2 cycles, ready 50%, FIFO held full.
        base_done = n_done;
        base_pop  = n_pop;
        start_cap(1'b0);
        chk("t4_err_clr",  32'(err_o),      32'd0);
        chk("t4_code_clr", 32'(err_code_o), 32'd0);
        chk("t4_busy",     32'(busy_o),     32'd1);
        for (int k = 0; k < int'(DISC + FL); k++) begin
            da = DW'($urandom);
            if (k >= int'(DISC)) begin
                sb.push_back({(k - int'(DISC)) == int'(FL - 1), IW'(k - int'(DISC)), da});
            end
            smp_valid_i     = 1'b1;
            smp_data_i      = da;
            frm.frm_ready_i = (k >= int'(DISC) + 2);
            step();
            smp_valid_i     = 1'b0;
            frm.frm_ready_i = 1'b0;
            step();
        end
        frm.frm_ready_i = 1'b1;
        wait_done("t4", base_done);
        chk("t4_pops",     32'(n_pop - base_pop), 32'(FL));
        chk("t4_sb_empty", 32'(sb.size()),        32'd0);
        chk("t4_err",      32'(err_o),            32'd0);

        // Abort at sample 100, colliding with a strobe.
        base_done = n_done;
        start_cap(1'b1);
        strobe_seq(0, int'(DISC) + 100, 4);
        frm.frm_ready_i = 1'b0;
        smp_valid_i = 1'b1; smp_data_i = DW'($urandom); step(); smp_valid_i = 1'b0;
        chk("t5_valid_pre", 32'(frm.frm_valid_o), 32'd1);
        chk("t5_idx_pre",   32'(frm.frm_idx_o),   32'd100);
        abort_i = 1'b1; smp_valid_i = 1'b1; step();
        abort_i = 1'b0; smp_valid_i = 1'b0;
        chk("t5_err_code", 32'(err_code_o),      32'(ERR_ABORT));
        chk("t5_err",      32'(err_o),           32'd1);
        chk("t5_valid",    32'(frm.frm_valid_o), 32'd0);
        chk("t5_mic_en",   32'(mic_en_o),        32'd0);
        repeat (10) step();
        chk("t5_no_done",  32'(n_done - base_done), 32'd0);

        // Reset mid-frame, then a clean frame.
        frm.frm_ready_i = 1'b1;
        start_cap(1'b0);
        strobe_seq(0, int'(DISC) + 50, 4);
        frm.frm_ready_i = 1'b0;
        smp_valid_i = 1'b1; smp_data_i = DW'($urandom); step(); smp_valid_i = 1'b0;
        chk("t6_valid_pre", 32'(frm.frm_valid_o), 32'd1);
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        chk_reset("t6");
        frm.frm_ready_i = 1'b1;
        base_done = n_done;
        base_pop  = n_pop;
        start_cap(1'b1);
        strobe_seq(0, int'(DISC + FL), 3);
        wait_done("t6", base_done);
        chk("t6_pops",     32'(n_pop - base_pop), 32'(FL));
        chk("t6_sb_empty", 32'(sb.size()),        32'd0);
        chk("t6_err",      32'(err_o),            32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
